// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver with a first-word-fall-through receive FIFO.
//
// Ports:
//   clk, reset             sole clock (rising edge) and synchronous active-high reset
//   ps2_clk_i, ps2_data_i  asynchronous PS/2 bus inputs
//   rx_data, rx_valid      head-of-FIFO byte and FIFO non-empty
//   rx_ready               consumer pop (effective when rx_valid is also 1)
//   fifo_count             bytes held, 0..FIFO_DEPTH
//   parity_err, frame_err  sticky frame-discard flags
//   overflow               sticky: good frame dropped on a full FIFO
//   err_clear              pulse clearing the sticky flags (a same-cycle set wins)
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [4:0] fifo_count,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  input  logic       err_clear
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchronizers; reset to the idle bus level so reset release makes no edge.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;

  logic fall_edge, push, push_ok, pop, full, set_par, set_frm, set_ovf;

  assign fall_edge = clk_prev_q & ~clk_sync_q;
  assign full      = (count_q == 5'(FIFO_DEPTH));
  assign pop       = rx_valid & rx_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = push & (~full | pop);
  assign set_ovf   = push & full & ~pop;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    to_cnt_d  = '0;
    push      = 1'b0;
    set_par   = 1'b0;
    set_frm   = 1'b0;

    if (state_q != StIdle) begin
      if (!fall_edge) begin
        if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
          set_frm   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
    end

    if (fall_edge) begin
      unique case (state_q)
        StIdle: begin
          if (!data_sync_q) begin
            state_d   = StData;
            bit_cnt_d = '0;
          end
        end
        StData: begin
          shift_d = {data_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d   = StParity;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        StParity: begin
          parity_d = data_sync_q;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (!data_sync_q)                  set_frm = 1'b1;
          else if (!(^{shift_q, parity_q}))  set_par = 1'b1;
          else                               push    = 1'b1;
        end
        default: state_d = StIdle;
      endcase
    end

    parity_err_d = (parity_err_q & ~err_clear) | set_par;
    frame_err_d  = (frame_err_q & ~err_clear) | set_frm;
    overflow_d   = (overflow_q & ~err_clear) | set_ovf;

    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + {4'd0, push_ok} - {4'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_q   <= 1'b1;
      clk_sync_q   <= 1'b1;
      clk_prev_q   <= 1'b1;
      data_meta_q  <= 1'b1;
      data_sync_q  <= 1'b1;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      clk_meta_q   <= ps2_clk_i;
      clk_sync_q   <= clk_meta_q;
      clk_prev_q   <= clk_sync_q;
      data_meta_q  <= ps2_data_i;
      data_sync_q  <= data_meta_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset; rx_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign rx_valid   = (count_q != 5'd0);
  assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count = count_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000: idle clk cycles between ps2 clock falling edges that abort a frame (1 ms at 100 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: receive FIFO entries, power of two, 2..16.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk_i  input  1  asynchronous PS/2 clock, input side of the ps2_clk pad.
REQ-006 SHALL have port ps2_data_i  input  1  asynchronous PS/2 data, input side of the ps2_data pad.
REQ-007 SHALL have port rx_data  output  8  head-of-FIFO scan code byte, valid while rx_valid=1.
REQ-008 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port rx_ready  input  1  consumer pop; a byte is popped when rx_valid and rx_ready are both 1.
REQ-010 SHALL have port fifo_count  output  5  bytes currently held, 0..FIFO_DEPTH.
REQ-011 SHALL have port parity_err  output  1  sticky: frame discarded for bad parity.
REQ-012 SHALL have port frame_err  output  1  sticky: frame discarded for bad stop bit or timeout.
REQ-013 SHALL have port overflow  output  1  sticky: valid frame dropped because the FIFO was full.
REQ-014 SHALL have port err_clear  input  1  single-cycle pulse clearing all three sticky flags.

Function
REQ-015 SHALL pass ps2_clk_i and ps2_data_i through 2-flop synchronizers, then register once more; a falling edge is detected when the previous synchronized clock is 1 and the current is 0.
REQ-016 SHALL sample synchronized data only in the cycle a falling edge is detected.
REQ-017 SHALL implement states IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: on an edge with data=0 go to DATA with bit counter 0; an edge with data=1 is ignored and the state stays IDLE.
REQ-019 DATA: shift data in LSB first on each edge; after the 8th bit go to PARITY.
REQ-020 PARITY: capture the parity bit on the edge and go to STOP.
REQ-021 STOP: on the edge, accept the frame if stop=1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity), then return to IDLE.
REQ-022 STOP: if stop=0, discard the frame and set frame_err; if stop=1 but parity is wrong, discard the frame and set parity_err; if both are wrong, set frame_err only.
REQ-023 In DATA, PARITY or STOP, SHALL count clk cycles since the last edge; reaching TIMEOUT_CYCLES returns to IDLE, discards the partial frame, and sets frame_err; the counter SHALL be 0 in IDLE.
REQ-024 An accepted byte SHALL be written to the FIFO on the clock edge that ends the STOP-edge cycle, and rx_valid SHALL be 1 in the following cycle when the FIFO was empty.
REQ-025 The FIFO SHALL be first-word-fall-through: rx_data equals the oldest entry with no read latency, and is preserved in order.
REQ-026 Push when full without a pop SHALL drop the new byte, leave contents unchanged, and set overflow.
REQ-027 Push and pop in the same cycle SHALL both succeed at any occupancy, including full; fifo_count is then unchanged and overflow is not set.
REQ-028 Pop when empty SHALL be ignored; rx_data is don't-care while rx_valid=0.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-030 If err_clear and a flag-set event occur in the same cycle, set SHALL win.

Reset
REQ-031 reset SHALL force state=IDLE, bit counter=0, timeout counter=0, FIFO empty, rx_valid=0, rx_data=0x00, fifo_count=0, and parity_err, frame_err and overflow all 0.
REQ-032 reset asserted mid-frame SHALL abort the frame with no push and no flag set.
REQ-033 Synchronizer flops SHALL reset to 1, the idle bus level, so that reset release does not produce a false edge.

Verification
REQ-034 Frame 0x1C with parity 0 and stop 1, rx_ready=0 -> rx_data=0x1C, rx_valid=1, fifo_count=1, all flags 0.
REQ-035 Frame 0x1C with parity 1 -> fifo_count stays 0, parity_err=1; err_clear pulse -> parity_err=0.
REQ-036 Frames 0x01..0x09 with rx_ready=0 -> fifo_count=8, overflow=1; popping yields 0x01..0x08 in order, and 0x09 is lost.
REQ-037 FIFO full and a new frame's STOP edge coinciding with a pop -> fifo_count stays 8, overflow=0, and the last pop-out is the new byte.
REQ-038 Start bit plus 4 data bits, then bus idle for TIMEOUT_CYCLES -> frame_err=1 and no push; the next frame 0xF0 is received correctly.
REQ-039 reset pulse after 5 bits of a frame -> all outputs at reset values; a subsequent full frame 0x5A is received with no flags set.
